// File: rtl/sift_pkg.sv
// Types shared across the SIFT pipeline: scheduler states, width helpers and
// the {octave, x, y} keypoint record layout used by descriptor generation.
package sift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } sched_state_t;

    function automatic int xy_width(input int dimension);
        return 2 * $clog2(dimension);
    endfunction

    function automatic int oct_width(input int number_octaves);
        return (number_octaves > 1) ? $clog2(number_octaves) : 1;
    endfunction

    // A keypoint record is {octave, x, y}: the octave tag sits above the packed xy.
    function automatic int key_width(input int dimension, input int number_octaves);
        return xy_width(dimension) + oct_width(number_octaves);
    endfunction

endpackage

// File: rtl/keypoint_write_port.sv
// Single write port into the keypoint BRAM: address counter, full/overflow
// detection and registered {octave, x, y} write data.
module keypoint_write_port
    import sift_pkg::*;
#(
    parameter int NUMBER_KEYPOINTS = 1000,
    parameter int XY_W             = 12,
    parameter int OCT_W            = 2,
    parameter int KA_W             = $clog2(NUMBER_KEYPOINTS)
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    clear,
    input  logic                    key_valid,
    input  logic [XY_W-1:0]         key_xy,
    input  logic [OCT_W-1:0]        key_octave,
    output logic [KA_W-1:0]         key_write_addr,
    output logic                    key_wea,
    output logic [XY_W+OCT_W-1:0]   key_out,
    output logic [KA_W:0]           key_count,
    output logic                    overflow
);

    localparam logic [KA_W:0] KEY_FULL = (KA_W + 1)'(NUMBER_KEYPOINTS);

    logic [KA_W-1:0]       addr_q, addr_d;
    logic                  wea_q, wea_d;
    logic [XY_W+OCT_W-1:0] out_q, out_d;
    logic [KA_W:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;

    always_comb begin
        addr_d     = addr_q;
        wea_d      = 1'b0;
        out_d      = out_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (key_valid) begin
            // Once the BRAM is full further keypoints are dropped, never wrapped.
            if (count_q != KEY_FULL) begin
                wea_d   = 1'b1;
                addr_d  = count_q[KA_W-1:0];
                out_d   = {key_octave, key_xy};
                count_d = count_q + (KA_W + 1)'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            addr_q     <= '0;
            wea_q      <= 1'b0;
            out_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wea_q      <= wea_d;
            out_q      <= out_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign key_write_addr = addr_q;
    assign key_wea        = wea_q;
    assign key_out        = out_q;
    assign key_count      = count_q;
    assign overflow       = overflow_q;

endmodule

// File: rtl/octave_keypoint_scheduler.sv
// Runs the shared DoG+extrema engine once per pyramid octave with a per-octave
// watchdog, and funnels tagged keypoints into the keypoint BRAM write port.
module octave_keypoint_scheduler
    import sift_pkg::*;
#(
    parameter  int DIMENSION        = 64,
    parameter  int NUMBER_OCTAVES   = 3,
    parameter  int NUMBER_KEYPOINTS = 1000,
    parameter  int TIMEOUT          = 2**20,
    localparam int XY_W             = xy_width(DIMENSION),
    localparam int OCT_W            = oct_width(NUMBER_OCTAVES),
    localparam int KA_W             = $clog2(NUMBER_KEYPOINTS),
    localparam int DIM_W            = $clog2(DIMENSION) + 1
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  keypoints_done,
    output logic                  error,
    output logic                  overflow,
    output logic                  eng_start,
    output logic [OCT_W-1:0]      eng_octave,
    output logic [DIM_W-1:0]      eng_dim,
    input  logic                  eng_done,
    input  logic                  eng_key_valid,
    input  logic [XY_W-1:0]       eng_key_xy,
    output logic [KA_W-1:0]       key_write_addr,
    output logic                  key_wea,
    output logic [XY_W+OCT_W-1:0] key_out,
    output logic [KA_W:0]         key_count
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [OCT_W-1:0] LAST_OCTAVE = OCT_W'(NUMBER_OCTAVES - 1);
    // The abort decision is taken on the cycle the incremented count would hit TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 2);

    sched_state_t     state_q, state_d;
    logic [OCT_W-1:0] octave_q, octave_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             eng_start_q, eng_start_d;
    logic             start_accept;
    logic             key_accept;

    always_comb begin
        state_d      = state_q;
        octave_d     = octave_q;
        wd_d         = wd_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        eng_start_d  = 1'b0;
        start_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = LAUNCH;
                    octave_d     = '0;
                    wd_d         = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    eng_start_d  = 1'b1;
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (eng_done) begin
                    if (octave_q == LAST_OCTAVE) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        octave_d    = octave_q + OCT_W'(1);
                        state_d     = LAUNCH;
                        eng_start_d = 1'b1;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= IDLE;
            octave_q    <= '0;
            wd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            octave_q    <= octave_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            eng_start_q <= eng_start_d;
        end
    end

    // octave_q still holds the finishing octave on the eng_done edge, so a
    // coincident keypoint is tagged with the octave that produced it.
    assign key_accept = eng_key_valid && (state_q != IDLE);

    keypoint_write_port #(
        .NUMBER_KEYPOINTS (NUMBER_KEYPOINTS),
        .XY_W             (XY_W),
        .OCT_W            (OCT_W),
        .KA_W             (KA_W)
    ) u_write_port (
        .clk            (clk),
        .srst           (rst_in),
        .clear          (start_accept),
        .key_valid      (key_accept),
        .key_xy         (eng_key_xy),
        .key_octave     (octave_q),
        .key_write_addr (key_write_addr),
        .key_wea        (key_wea),
        .key_out        (key_out),
        .key_count      (key_count),
        .overflow       (overflow)
    );

    assign busy           = busy_q;
    assign keypoints_done = done_q;
    assign error          = error_q;
    assign eng_start      = eng_start_q;
    assign eng_octave     = octave_q;
    assign eng_dim        = DIM_W'(DIMENSION >> octave_q);

endmodule

// File: tb/tb_octave_keypoint_scheduler.sv
// Directed bench for octave_keypoint_scheduler: a scoreboard holds expected
// engine launches and BRAM writes, and a negedge monitor pops them as they appear.
module tb_octave_keypoint_scheduler;

    localparam int DIMENSION        = 64;
    localparam int NUMBER_OCTAVES   = 3;
    localparam int NUMBER_KEYPOINTS = 4;
    localparam int TIMEOUT          = 16;
    localparam int XY_W  = 12;
    localparam int OCT_W = 2;
    localparam int KA_W  = 2;
    localparam int DIM_W = 7;

    logic                  clk = 1'b0;
    logic                  rst_in;
    logic                  start;
    logic                  busy;
    logic                  keypoints_done;
    logic                  error;
    logic                  overflow;
    logic                  eng_start;
    logic [OCT_W-1:0]      eng_octave;
    logic [DIM_W-1:0]      eng_dim;
    logic                  eng_done;
    logic                  eng_key_valid;
    logic [XY_W-1:0]       eng_key_xy;
    logic [KA_W-1:0]       key_write_addr;
    logic                  key_wea;
    logic [XY_W+OCT_W-1:0] key_out;
    logic [KA_W:0]         key_count;

    int checks = 0;
    int errors = 0;

    logic [OCT_W+DIM_W-1:0]       start_exp_q[$];
    logic [KA_W+OCT_W+XY_W-1:0]   key_exp_q[$];
    logic [XY_W-1:0]              key_stim_q[$];
    int m_count;
    int m_oct;

    octave_keypoint_scheduler #(
        .DIMENSION        (DIMENSION),
        .NUMBER_OCTAVES   (NUMBER_OCTAVES),
        .NUMBER_KEYPOINTS (NUMBER_KEYPOINTS),
        .TIMEOUT          (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .start          (start),
        .busy           (busy),
        .keypoints_done (keypoints_done),
        .error          (error),
        .overflow       (overflow),
        .eng_start      (eng_start),
        .eng_octave     (eng_octave),
        .eng_dim        (eng_dim),
        .eng_done       (eng_done),
        .eng_key_valid  (eng_key_valid),
        .eng_key_xy     (eng_key_xy),
        .key_write_addr (key_write_addr),
        .key_wea        (key_wea),
        .key_out        (key_out),
        .key_count      (key_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every launch and every BRAM write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (eng_start === 1'b1) begin
            checks++;
            if (start_exp_q.size() == 0) begin
                errors++;
                $display("FAIL eng_start_unexpected: octave %0d dim %0d", eng_octave, eng_dim);
            end else begin
                logic [OCT_W+DIM_W-1:0] e;
                e = start_exp_q.pop_front();
                if ({eng_octave, eng_dim} !== e) begin
                    errors++;
                    $display("FAIL eng_start_params: got octave %0d dim %0d, expected octave %0d dim %0d",
                             eng_octave, eng_dim, e[OCT_W+DIM_W-1:DIM_W], e[DIM_W-1:0]);
                end
                $display("launch: octave %0d dim %0d", eng_octave, eng_dim);
            end
        end
        if (key_wea === 1'b1) begin
            checks++;
            if (key_exp_q.size() == 0) begin
                errors++;
                $display("FAIL key_write_unexpected: addr %0d key_out 0x%0h", key_write_addr, key_out);
            end else begin
                logic [KA_W+OCT_W+XY_W-1:0] k;
                k = key_exp_q.pop_front();
                if ({key_write_addr, key_out} !== k) begin
                    errors++;
                    $display("FAIL key_write: got addr %0d key_out 0x%0h, expected addr %0d key_out 0x%0h",
                             key_write_addr, key_out, k[KA_W+OCT_W+XY_W-1:OCT_W+XY_W], k[OCT_W+XY_W-1:0]);
                end
                $display("write: addr %0d key_out 0x%0h", key_write_addr, key_out);
            end
        end
    end

    task automatic expect_starts(input int n);
        for (int i = 0; i < n; i++)
            start_exp_q.push_back({OCT_W'(i), DIM_W'(DIMENSION >> i)});
    endtask

    task automatic expect_key(input logic [XY_W-1:0] xy);
        if (m_count < NUMBER_KEYPOINTS) begin
            key_exp_q.push_back({KA_W'(m_count), OCT_W'(m_oct), xy});
            m_count++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_count = 0;
        check("start_busy", busy, 1);
        check("start_done_cleared", keypoints_done, 0);
        check("start_error_cleared", error, 0);
        check("start_overflow_cleared", overflow, 0);
        check("start_count_cleared", key_count, 0);
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (eng_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("eng_start_seen", eng_start, 1);
    endtask

    // Engine model for one octave: emits queued keypoints back-to-back, then
    // signals done done_delay cycles after the launch cycle.
    task automatic engine_octave(input int oct, input int done_delay,
                                 input logic [XY_W-1:0] done_xy, input bit key_on_done);
        int n;
        wait_start(40);
        m_oct = oct;
        n = 0;
        @(negedge clk);
        n++;
        while (key_stim_q.size() > 0) begin
            eng_key_valid = 1'b1;
            eng_key_xy    = key_stim_q.pop_front();
            expect_key(eng_key_xy);
            @(negedge clk);
            n++;
        end
        eng_key_valid = 1'b0;
        while (n < done_delay) begin
            @(negedge clk);
            n++;
        end
        eng_done = 1'b1;
        if (key_on_done) begin
            eng_key_valid = 1'b1;
            eng_key_xy    = done_xy;
            expect_key(done_xy);
        end
        @(negedge clk);
        eng_done      = 1'b0;
        eng_key_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, keypoints_done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_octave"}, eng_octave, 0);
        check({tag, "_eng_dim"}, eng_dim, DIMENSION);
        check({tag, "_key_wea"}, key_wea, 0);
        check({tag, "_key_addr"}, key_write_addr, 0);
        check({tag, "_key_out"}, key_out, 0);
        check({tag, "_key_count"}, key_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst_in = 1'b1; start = 1'b0; eng_done = 1'b0;
        eng_key_valid = 1'b0; eng_key_xy = '0;
        m_count = 0; m_oct = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        @(negedge clk);

        // Plain three-octave run, with a start pulse while busy that must be ignored.
        expect_starts(3);
        do_start();
        engine_octave(0, 10, '0, 1'b0);
        wait_start(40);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored_busy", busy, 1);
        check("busy_start_ignored_octave", eng_octave, 1);
        repeat (6) @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        engine_octave(2, 10, '0, 1'b0);
        check("run1_done", keypoints_done, 1);
        check("run1_busy", busy, 0);
        check("run1_count", key_count, 0);
        check("run1_error", error, 0);
        check("run1_dim_last", eng_dim, 16);

        // Keypoints in octaves 0 and 2; the last one arrives with the final done.
        expect_starts(3);
        do_start();
        key_stim_q = '{12'h105, 12'h20A};
        engine_octave(0, 10, '0, 1'b0);
        engine_octave(1, 10, '0, 1'b0);
        engine_octave(2, 10, 12'hFFF, 1'b1);
        check("run2_final_write_with_done", {keypoints_done, key_wea}, 2'b11);
        check("run2_count", key_count, 3);
        check("run2_overflow", overflow, 0);

        // Six back-to-back keypoints into a four-entry BRAM.
        expect_starts(3);
        do_start();
        key_stim_q = '{12'h011, 12'h012, 12'h013, 12'h014, 12'h015, 12'h016};
        engine_octave(0, 10, '0, 1'b0);
        check("ovf_count_mid", key_count, 4);
        check("ovf_flag_mid", overflow, 1);
        engine_octave(1, 10, '0, 1'b0);
        engine_octave(2, 10, '0, 1'b0);
        check("ovf_count_end", key_count, 4);
        check("ovf_flag_end", overflow, 1);
        check("ovf_done", keypoints_done, 1);

        // Keypoint on the octave-0 done, then octave 1 never finishes.
        expect_starts(2);
        do_start();
        engine_octave(0, 5, 12'hABC, 1'b1);
        wait_start(40);
        n = 0;
        while (error !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 16);
        check("timeout_done", keypoints_done, 1);
        check("timeout_busy", busy, 0);
        check("timeout_octave", eng_octave, 1);
        eng_done = 1'b1; eng_key_valid = 1'b1; eng_key_xy = 12'h777;
        @(negedge clk);
        eng_done = 1'b0; eng_key_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("idle_ignore_count", key_count, 1);
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_error", error, 1);
        check("idle_ignore_done", keypoints_done, 1);

        // Reset during octave 1, then a clean re-run from octave 0.
        expect_starts(2);
        do_start();
        key_stim_q = '{12'h123};
        engine_octave(0, 10, '0, 1'b0);
        wait_start(40);
        repeat (3) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_in = 1'b0;
        @(negedge clk);
        expect_starts(3);
        do_start();
        key_stim_q = '{12'h456};
        engine_octave(0, 10, '0, 1'b0);
        engine_octave(1, 10, '0, 1'b0);
        engine_octave(2, 10, '0, 1'b0);
        check("rerun_count", key_count, 1);
        check("rerun_done", keypoints_done, 1);

        repeat (3) @(negedge clk);
        check("pending_launches", start_exp_q.size(), 0);
        check("pending_writes", key_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
